// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the CPU/loader memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bundle for one requester of the shared RAM port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);

  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of CPU grants made while the loader is kept waiting.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic ld_req,
  input  logic cpu_gnt,
  input  logic ld_gnt,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_gnt || (idle && !ld_req)) begin
      cnt_d = '0;
    end else if (cpu_gnt && ld_req && (cnt_q != STARVE_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  // at_max is registered alongside the count so arbitration sees a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      at_max <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      at_max <= (cnt_d == STARVE_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and loader accesses onto the single-port RAM; CPU has priority,
// loader wins while the CPU is halted or after STARVE_MAX back-to-back CPU grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clock,
  input  logic           reset,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave ld,
  input  logic           cpu_halted,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy,
  output logic           grant_ld
);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               owner_q, owner_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_d;
  logic [DW-1:0]      wdata_d;
  logic [DW-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]      ld_rdata_q, ld_rdata_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               ld_ack_q, ld_ack_d;
  logic               mem_en_d, mem_we_d, busy_d;
  logic               cpu_gnt_c, ld_gnt_c;
  logic               starve_at_max;

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clock   (clock),
    .reset   (reset),
    .idle    (state_q == ST_IDLE),
    .ld_req  (ld.req),
    .cpu_gnt (cpu_gnt_c),
    .ld_gnt  (ld_gnt_c),
    .at_max  (starve_at_max)
  );

  // Next-state, request latch and registered-output decode.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    cpu_gnt_c   = 1'b0;
    ld_gnt_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ld.req && (cpu_halted || starve_at_max)) begin
          ld_gnt_c = 1'b1;
        end else if (cpu.req) begin
          cpu_gnt_c = 1'b1;
        end else if (ld.req) begin
          ld_gnt_c = 1'b1;
        end
        if (cpu_gnt_c) begin
          owner_d = OWN_CPU;
          we_d    = cpu.we;
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          state_d = ST_ISSUE;
        end else if (ld_gnt_c) begin
          owner_d = OWN_LD;
          we_d    = ld.we;
          addr_d  = ld.addr;
          wdata_d = ld.wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_W'(MEM_LAT - 1)) begin
          if (!we_q) begin
            if (owner_q == OWN_LD) ld_rdata_d  = mem_rdata;
            else                   cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_en_d  = (state_d == ST_ISSUE);
    mem_we_d  = (state_d == ST_ISSUE) && we_d;
    busy_d    = (state_d != ST_IDLE);
    cpu_ack_d = (state_d == ST_RESP) && (owner_q == OWN_CPU);
    ld_ack_d  = (state_d == ST_RESP) && (owner_q == OWN_LD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      busy        <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign grant_ld  = owner_q;
  assign cpu.ack   = cpu_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign ld.ack    = ld_ack_q;
  assign ld.rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural MEM_LAT-cycle RAM.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 8;
  localparam int unsigned DW         = 8;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic          clock;
  logic          reset;
  logic          cpu_halted;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          grant_ld;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ld_if ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu        (cpu_if),
    .ld         (ld_if),
    .cpu_halted (cpu_halted),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .grant_ld   (grant_ld)
  );

  always #5 clock = ~clock;

  // RAM model: data read in the enable cycle appears MEM_LAT cycles later, for one cycle.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_pipe [MEM_LAT];

  always @(posedge clock) begin
    if (reset) begin
      ram[8'h0A] <= 8'h3C;
      for (int i = 0; i < int'(MEM_LAT); i++) rd_pipe[i] <= 8'h00;
    end else begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'h00;
      for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit is_ld, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (is_ld) begin
      ld_if.req = 1'b1; ld_if.we = we; ld_if.addr = addr; ld_if.wdata = wdata;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
  endtask

  task automatic drain(output bit ok);
    cpu_if.req = 1'b0;
    ld_if.req  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy && !cpu_if.ack && !ld_if.ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs both ports, dropping each req the cycle after its ack; records first-ack cycles.
  task automatic run_pair(input int max_cyc, output int cpu_ack_cyc, output int ld_ack_cyc,
                          output logic gl_c1, output bit ok);
    bit drop_cpu = 1'b0;
    bit drop_ld  = 1'b0;
    cpu_ack_cyc = -1;
    ld_ack_cyc  = -1;
    gl_c1       = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (drop_cpu) cpu_if.req = 1'b0;
      if (drop_ld)  ld_if.req  = 1'b0;
      drop_cpu = 1'b0;
      drop_ld  = 1'b0;
      if (c == 1) gl_c1 = grant_ld;
      if (cpu_if.ack === 1'b1 && cpu_ack_cyc < 0) begin cpu_ack_cyc = c; drop_cpu = 1'b1; end
      if (ld_if.ack  === 1'b1 && ld_ack_cyc  < 0) begin ld_ack_cyc  = c; drop_ld  = 1'b1; end
    end
    drain(ok);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({mem_en, mem_we, busy, grant_ld, cpu_if.ack, ld_if.ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: en/we/busy/gld/cack/lack=%b required 000000",
               {mem_en, mem_we, busy, grant_ld, cpu_if.ack, ld_if.ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_if.rdata, ld_if.rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h crd=%h lrd=%h required all 00",
               mem_addr, mem_wdata, cpu_if.rdata, ld_if.rdata);
    end
  endtask

  task automatic test_cpu_read();
    issue(1'b0, 1'b0, 8'h0A, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h0A || busy !== 1'b1) begin
          errors++;
          $display("FAIL cpu_read_issue: en=%b we=%b addr=%h busy=%b required 1 0 0a 1",
                   mem_en, mem_we, mem_addr, busy);
        end
      end else if (c < 4) begin
        checks++;
        if (mem_en !== 1'b0 || cpu_if.ack !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL cpu_read_wait c%0d: en=%b ack=%b busy=%b required 0 0 1",
                   c, mem_en, cpu_if.ack, busy);
        end
      end else begin
        checks++;
        if (cpu_if.ack !== 1'b1 || cpu_if.rdata !== 8'h3C) begin
          errors++;
          $display("FAIL cpu_read_ack: ack=%b rdata=%h required 1 3c", cpu_if.ack, cpu_if.rdata);
        end
        checks++;
        if (ld_if.ack !== 1'b0) begin
          errors++;
          $display("FAIL cpu_read_ld_ack: ld_ack=%b required 0", ld_if.ack);
        end
      end
    end
    tick();
    cpu_if.req = 1'b0;
    checks++;
    if (cpu_if.ack !== 1'b0 || busy !== 1'b0 || cpu_if.rdata !== 8'h3C) begin
      errors++;
      $display("FAIL cpu_read_after: ack=%b busy=%b rdata=%h required 0 0 3c",
               cpu_if.ack, busy, cpu_if.rdata);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_no_regrant: busy=%b required 0", busy);
    end
  endtask

  task automatic test_write_then_read();
    int ca, la;
    logic gl;
    bit ok;
    issue(1'b1, 1'b1, 8'h10, 8'h5A);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 ||
            mem_wdata !== 8'h5A || grant_ld !== 1'b1) begin
          errors++;
          $display("FAIL ld_write_issue: en=%b we=%b addr=%h wdata=%h gld=%b required 1 1 10 5a 1",
                   mem_en, mem_we, mem_addr, mem_wdata, grant_ld);
        end
      end else if (c < 4) begin
        checks++;
        if (mem_we !== 1'b0 || mem_en !== 1'b0 || ld_if.ack !== 1'b0) begin
          errors++;
          $display("FAIL ld_write_wait c%0d: en=%b we=%b ack=%b required 0 0 0",
                   c, mem_en, mem_we, ld_if.ack);
        end
      end else begin
        checks++;
        if (ld_if.ack !== 1'b1 || cpu_if.ack !== 1'b0 || ld_if.rdata !== 8'h00) begin
          errors++;
          $display("FAIL ld_write_ack: ld_ack=%b cpu_ack=%b ld_rdata=%h required 1 0 00",
                   ld_if.ack, cpu_if.ack, ld_if.rdata);
        end
      end
    end
    tick();
    ld_if.req = 1'b0;
    ld_if.we  = 1'b0;
    issue(1'b0, 1'b0, 8'h10, 8'h00);
    run_pair(10, ca, la, gl, ok);
    checks++;
    if (ca !== 4 || la !== -1 || cpu_if.rdata !== 8'h5A || ld_if.rdata !== 8'h00 || !ok) begin
      errors++;
      $display("FAIL cpu_read_back: ack_cyc=%0d ld_ack_cyc=%0d crd=%h lrd=%h idle=%b required 4 -1 5a 00 1",
               ca, la, cpu_if.rdata, ld_if.rdata, ok);
    end
  endtask

  task automatic test_both_same_cycle();
    int ca, la;
    logic gl;
    bit ok;
    issue(1'b0, 1'b0, 8'h0A, 8'h00);
    issue(1'b1, 1'b0, 8'h10, 8'h00);
    run_pair(12, ca, la, gl, ok);
    checks++;
    if (ca !== 4 || la !== 9 || gl !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL both_order: cpu_ack=%0d ld_ack=%0d gld_c1=%b idle=%b required 4 9 0 1",
               ca, la, gl, ok);
    end
    checks++;
    if (cpu_if.rdata !== 8'h3C || ld_if.rdata !== 8'h5A || grant_ld !== 1'b1) begin
      errors++;
      $display("FAIL both_data: crd=%h lrd=%h gld=%b required 3c 5a 1",
               cpu_if.rdata, ld_if.rdata, grant_ld);
    end
  endtask

  task automatic test_starvation();
    int cpu_acks = 0;
    int cpu_before = -1;
    int la = -1;
    logic [3:0] cnt_snap = 4'hF;
    bit drop_ld = 1'b0;
    bit ok;
    issue(1'b0, 1'b0, 8'h0A, 8'h00);
    issue(1'b1, 1'b0, 8'h10, 8'h00);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (drop_ld) ld_if.req = 1'b0;
      drop_ld = 1'b0;
      if (c == 21) cnt_snap = dut.u_starve.cnt_q;
      if (cpu_if.ack === 1'b1) cpu_acks++;
      if (ld_if.ack === 1'b1 && la < 0) begin
        la = c;
        cpu_before = cpu_acks;
        drop_ld = 1'b1;
      end
    end
    drain(ok);
    checks++;
    if (cpu_before !== 4 || la !== 24) begin
      errors++;
      $display("FAIL starve_bound: cpu_grants_before=%0d ld_ack_cyc=%0d required 4 24",
               cpu_before, la);
    end
    checks++;
    if (cnt_snap !== 4'd0) begin
      errors++;
      $display("FAIL starve_clear: cnt=%0d required 0", cnt_snap);
    end
    checks++;
    if (cpu_acks !== 5 || !ok) begin
      errors++;
      $display("FAIL starve_resume: cpu_acks=%0d idle=%b required 5 1", cpu_acks, ok);
    end
  endtask

  task automatic test_halted();
    int ca, la;
    logic gl;
    bit ok;
    cpu_halted = 1'b1;
    issue(1'b0, 1'b0, 8'h20, 8'h00);
    issue(1'b1, 1'b1, 8'h20, 8'h77);
    run_pair(12, ca, la, gl, ok);
    cpu_halted = 1'b0;
    checks++;
    if (la !== 4 || ca !== 9 || gl !== 1'b1 || !ok) begin
      errors++;
      $display("FAIL halted_order: ld_ack=%0d cpu_ack=%0d gld_c1=%b idle=%b required 4 9 1 1",
               la, ca, gl, ok);
    end
    checks++;
    if (cpu_if.rdata !== 8'h77 || grant_ld !== 1'b0) begin
      errors++;
      $display("FAIL halted_data: crd=%h gld=%b required 77 0", cpu_if.rdata, grant_ld);
    end
  endtask

  task automatic test_reset_mid();
    int ack_seen = 0;
    int ca = -1;
    bit ok;
    issue(1'b0, 1'b0, 8'h10, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    cpu_if.req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_if.ack !== 1'b0 || cpu_if.rdata !== 8'h00 ||
        mem_en !== 1'b0 || grant_ld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ack=%b rdata=%h en=%b gld=%b required 0 0 00 0 0",
               busy, cpu_if.ack, cpu_if.rdata, mem_en, grant_ld);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpu_if.ack === 1'b1 || busy === 1'b1) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_ack: activity_cycles=%0d required 0", ack_seen);
    end
    issue(1'b0, 1'b0, 8'h10, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (cpu_if.ack === 1'b1 && ca < 0) begin
        ca = c;
        checks++;
        if (cpu_if.rdata !== 8'h5A) begin
          errors++;
          $display("FAIL reset_mid_reissue_data: rdata=%h required 5a", cpu_if.rdata);
        end
        cpu_if.req = 1'b0;
      end
    end
    drain(ok);
    checks++;
    if (ca !== 4 || !ok) begin
      errors++;
      $display("FAIL reset_mid_reissue: ack_cyc=%0d idle=%b required 4 1", ca, ok);
    end
  endtask

  initial begin
    clock      = 1'b0;
    reset      = 1'b1;
    cpu_halted = 1'b0;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ld_if.req  = 1'b0; ld_if.we  = 1'b0; ld_if.addr  = '0; ld_if.wdata  = '0;
    test_reset();
    test_cpu_read();
    test_write_then_read();
    test_both_same_cycle();
    test_starvation();
    test_halted();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port synchronous program/data RAM between two requesters: the CPU controller (fetch, LDA/STA/ADD operand access) and an external program loader/debug port.
- Serialises accesses and gives the CPU priority. The loader is guaranteed progress through a starvation bound, and wins outright while the CPU is halted (HLT).
- Sits between the controller/datapath memory interface and the RAM macro.

Parameters:
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 2, RAM read latency in cycles from the enable cycle to valid mem_rdata (range 1..7)
- STARVE_MAX, 4, consecutive CPU grants allowed while the loader waits (range 1..15)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  CPU address; stable while cpu_req is high
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  last CPU read data; held until the next CPU read completes
- cpu_halted  in  1  CPU is in the halt state; loader has absolute priority
- ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata  same as the cpu_* ports, for the loader
- mem_en  out  1  RAM enable; one-cycle pulse per access
- mem_we  out  1  RAM write strobe; qualified by mem_en
- mem_addr  out  AW  RAM address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data
- busy  out  1  high in every state except IDLE
- grant_ld  out  1  the current or last grant went to the loader

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; cpu_rdata = ld_rdata = 0.
- States: IDLE → ISSUE → WAIT → RESP → IDLE. Encoding comes from the package.
- IDLE arbitration:
  - No request: stay in IDLE.
  - Winner order: loader if cpu_halted=1 and ld_req=1; else loader if ld_req=1 and starve_cnt == STARVE_MAX; else CPU if cpu_req=1; else loader if ld_req=1.
  - On a grant: latch the winner's we/addr/wdata into the mem_* registers, set grant_ld, go to ISSUE.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we. Go to WAIT with the latency counter at 0.
- WAIT (MEM_LAT cycles):
  - The counter increments each cycle.
  - On the last WAIT cycle (counter == MEM_LAT-1), capture mem_rdata into the granted port's rdata register, reads only.
  - Writes leave rdata unchanged. Then go to RESP.
- RESP (1 cycle): pulse the granted port's ack, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 → ack high in cycle MEM_LAT+2; rdata valid in the ack cycle. Peak throughput is one access per MEM_LAT+3 cycles.
- Handshake:
  - The requester deasserts req in the cycle after ack.
  - req still high in IDLE after an ack counts as a new request.
  - Changing we/addr/wdata while req is high and before grant is legal; after grant the values are ignored (already latched).
- Starvation counter:
  - Increments on each CPU grant made while ld_req=1.
  - Clears on a loader grant or when ld_req=0 in IDLE.
  - Saturates at STARVE_MAX.
- Simultaneous requests: resolved only in IDLE per the order above. A request arriving mid-access waits and never preempts.
- cpu_halted only affects arbitration in IDLE; toggling it mid-access has no effect on the access in flight.
- Reset mid-operation:
  - Returns to IDLE with all outputs cleared; no ack is issued for the aborted access.
  - A write issued before the reset has already reached the RAM; the requester must re-issue after reset.
- Only one ack is ever high at a time; mem_en is never high outside ISSUE.

Decomposition:
- Package mem_arb_pkg: state encoding constants (IDLE, ISSUE, WAIT, RESP), default AW/DW, and the owner encoding constant (OWN_CPU=0, OWN_LD=1).
- Sub-module mem_arb_starve_ctr: the saturating starvation counter. Inputs are cpu grant, ld_req, ld grant and reset; the output is the at_max flag.
- Arbitration and FSM stay in the top level.

Test Plan:
- CPU read: cpu_req, addr 0x0A, RAM holds 0x3C, MEM_LAT=2 → mem_en pulse in cycle 1 with mem_addr=0x0A; cpu_ack in cycle 4 with cpu_rdata=0x3C; ld_ack stays 0.
- Write then read: loader writes 0x5A to 0x10, then the CPU reads 0x10 → ld_ack after 4 cycles, mem_we=1 only in ISSUE; CPU read returns 0x5A; ld_rdata unchanged.
- Both requesters assert in the same IDLE cycle with cpu_halted=0 → CPU granted first; loader granted on the next arbitration.
- CPU re-requests continuously while the loader waits, STARVE_MAX=4 → four CPU grants, then a loader grant on the 5th; counter then reads 0.
- cpu_halted=1 with both requesting → loader granted; grant_ld=1; CPU waits until the loader access completes.
- Reset asserted during WAIT of a CPU read → next cycle in IDLE, busy=0, no cpu_ack, cpu_rdata=0; a fresh request afterwards completes normally.
